// File: rtl/demux_stream_1n_pkg.sv
// Shared constants and the parameter range check for the 1-to-N stream demux.
package demux_pkg;

  localparam int DEMUX_MAX_N = 16;
  localparam int DEMUX_MAX_W = 64;
  localparam int DROPCNT_W   = 8;

  // True when the channel count and data width are inside the supported range.
  function automatic bit demux_params_ok(input int n, input int w);
    return (n >= 2) && (n <= DEMUX_MAX_N) && (w >= 1) && (w <= DEMUX_MAX_W);
  endfunction

endpackage

// File: rtl/demux_stream_1n_if.sv
// Stream bundle for the 1-to-N demux.
// The master side is the producer plus the N consumers. The slave side is the demux.
interface demux_stream_1n_if #(
  parameter int N = 4,
  parameter int W = 8
);
  localparam int SW = $clog2(N);

  logic           in_valid;
  logic           in_ready;
  logic [SW-1:0]  in_sel;
  logic [W-1:0]   in_data;
  logic [N-1:0]   out_valid;
  logic [N-1:0]   out_ready;
  logic [N*W-1:0] out_data;

  modport master (
    output in_valid, in_sel, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_sel, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/demux_stream_1n_chan_reg.sv
// One output channel: a single data register plus its valid bit.
module demux_chan_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         drain,
  output logic         valid,
  output logic [W-1:0] data
);

  // A load wins over a drain so the same edge can hand a word out and take the next one.
  // Data is left untouched on drain; it only changes on a load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_stream_1n.sv
// 1-to-N stream demultiplexer with one holding register per output channel.
// Optional build macro DEMUX_DROPCNT_EN adds a saturating count of out-of-range selects.
module demux_stream_1n
  import demux_pkg::*;
#(
  parameter  int N  = 4,
  parameter  int W  = 8,
  localparam int SW = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  demux_stream_1n_if.slave     bus,
`ifdef DEMUX_DROPCNT_EN
  output logic [DROPCNT_W-1:0] drop_cnt,
`endif
  output logic                 busy
);

  if (!demux_params_ok(N, W)) begin : g_param_err
    $error("demux_stream_1n: N=%0d W=%0d outside supported range", N, W);
  end

  logic           sel_hit;
  logic           sel_ready;
  logic           ready_int;
  logic           xfer_in;
  logic [N-1:0]   load_vec;
  logic [N-1:0]   drain_vec;
  logic [N-1:0]   valid_vec;
  logic [N*W-1:0] data_vec;

  // Decode the select; the selected channel alone decides readiness (head-of-line),
  // and an out-of-range select is always accepted so it can be discarded.
  always_comb begin
    sel_hit   = 1'b0;
    sel_ready = 1'b1;
    load_vec  = '0;
    for (int k = 0; k < N; k++) begin
      if (bus.in_sel == SW'(k)) begin
        sel_hit   = 1'b1;
        sel_ready = ~valid_vec[k] | bus.out_ready[k];
      end
    end
    ready_int = sel_hit ? sel_ready : 1'b1;
    xfer_in   = bus.in_valid & ready_int;
    for (int k = 0; k < N; k++) begin
      load_vec[k] = xfer_in & (bus.in_sel == SW'(k));
    end
  end

  assign drain_vec     = valid_vec & bus.out_ready;
  assign bus.in_ready  = ready_int;
  assign bus.out_valid = valid_vec;
  assign bus.out_data  = data_vec;
  assign busy          = |valid_vec;

  for (genvar g = 0; g < N; g++) begin : g_chan
    demux_chan_reg #(.W(W)) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load_vec[g]),
      .load_data (bus.in_data),
      .drain     (drain_vec[g]),
      .valid     (valid_vec[g]),
      .data      (data_vec[g*W +: W])
    );
  end

`ifdef DEMUX_DROPCNT_EN
  // Count accepted words whose select names no channel; stick at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (xfer_in && !sel_hit && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_demux_stream_1n.sv
// Directed bench: DUT A (N=4) for routing, back-pressure, head-of-line and reset;
// DUT B (N=5) for out-of-range selects. Expected words go through per-channel queues.
module tb_demux_stream_1n;

  logic clk = 1'b0;
  logic rst_n;
  logic busy_a, busy_b;
`ifdef DEMUX_DROPCNT_EN
  logic [7:0] drop_a, drop_b;
`endif

  always #5 clk = ~clk;

  demux_stream_1n_if #(.N(4), .W(8)) ifa ();
  demux_stream_1n_if #(.N(5), .W(8)) ifb ();

  demux_stream_1n #(.N(4), .W(8)) u_dut_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (ifa),
`ifdef DEMUX_DROPCNT_EN
    .drop_cnt (drop_a),
`endif
    .busy     (busy_a)
  );

  demux_stream_1n #(.N(5), .W(8)) u_dut_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (ifb),
`ifdef DEMUX_DROPCNT_EN
    .drop_cnt (drop_b),
`endif
    .busy     (busy_b)
  );

  int         n_chk = 0;
  int         n_err = 0;
  bit         known = 1'b0;
  logic [3:0] mvalid;
  logic [7:0] mdata [4];
  logic [7:0] sb [4][$];
  int         bdrop = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_a(input logic v, input logic [1:0] s, input logic [7:0] d);
    ifa.in_valid = v;
    ifa.in_sel   = s;
    ifa.in_data  = d;
  endtask

  // Check the current state against the model, account for the transfers of the
  // coming edge, then advance one clock.
  task automatic tick();
    logic       exp_rdy;
    logic [7:0] e;
    #1;
    if (known) begin
      exp_rdy = ~mvalid[ifa.in_sel] | ifa.out_ready[ifa.in_sel];
      chk("a_in_ready", 64'(ifa.in_ready), 64'(exp_rdy));
      chk("a_out_valid", 64'(ifa.out_valid), 64'(mvalid));
      chk("a_busy", 64'(busy_a), 64'(|mvalid));
      for (int k = 0; k < 4; k++) chk($sformatf("a_out_data%0d", k), 64'(ifa.out_data[k*8 +: 8]), 64'(mdata[k]));
      chk("b_in_ready", 64'(ifb.in_ready), 64'(1'b1));
      chk("b_out_valid", 64'(ifb.out_valid), 64'(0));
`ifdef DEMUX_DROPCNT_EN
      chk("b_drop_cnt", 64'(drop_b), 64'(bdrop));
`endif
      if (rst_n) begin
        for (int k = 0; k < 4; k++) begin
          if (mvalid[k] && ifa.out_ready[k]) begin
            if (sb[k].size() == 0) begin
              chk($sformatf("a_sb_empty%0d", k), 64'(1), 64'(0));
            end else begin
              e = sb[k].pop_front();
              chk($sformatf("a_drain%0d", k), 64'(ifa.out_data[k*8 +: 8]), 64'(e));
            end
            mvalid[k] = 1'b0;
          end
        end
        if (ifa.in_valid && exp_rdy) begin
          sb[ifa.in_sel].push_back(ifa.in_data);
          mvalid[ifa.in_sel] = 1'b1;
          mdata[ifa.in_sel]  = ifa.in_data;
        end
        if (ifb.in_valid && (ifb.in_sel >= 3'd5) && (bdrop < 255)) bdrop++;
      end
    end
    @(posedge clk);
    if (!rst_n) begin
      known  = 1'b1;
      mvalid = '0;
      bdrop  = 0;
      for (int k = 0; k < 4; k++) begin
        mdata[k] = 8'h00;
        sb[k].delete();
      end
    end
    #1;
  endtask

  initial begin
    mvalid        = '0;
    ifa.out_ready = 4'hF;
    ifb.in_valid  = 1'b0;
    ifb.in_sel    = 3'd0;
    ifb.in_data   = 8'h00;
    ifb.out_ready = 5'h1F;

    // Reset with an offered word that must be ignored
    rst_n = 1'b0;
    drive_a(1'b1, 2'd0, 8'hAA);
    tick();
    tick();
    rst_n = 1'b1;
    drive_a(1'b0, 2'd0, 8'hAA);
    tick();
    tick();

    // Routing to all four channels back-to-back
    for (int i = 0; i < 4; i++) begin
      drive_a(1'b1, 2'(i), 8'h10 + 8'(i));
      tick();
    end
    drive_a(1'b0, 2'd0, 8'h00);
    tick();
    tick();

    // Back-pressure on channel 2, then drain and reload on the same edge
    ifa.out_ready = 4'b1011;
    drive_a(1'b1, 2'd2, 8'h55);
    tick();
    drive_a(1'b1, 2'd2, 8'h66);
    tick();
    tick();
    ifa.out_ready = 4'hF;
    tick();
    drive_a(1'b0, 2'd0, 8'h00);
    tick();
    tick();

    // Head-of-line: channel 1 stalled blocks input while channel 3 is empty
    ifa.out_ready = 4'b1101;
    drive_a(1'b1, 2'd1, 8'h21);
    tick();
    drive_a(1'b1, 2'd1, 8'h22);
    tick();
    tick();
    ifa.out_ready = 4'hF;
    tick();
    drive_a(1'b0, 2'd0, 8'h00);
    tick();
    tick();

    // Out-of-range selects on the five-channel instance
    ifb.in_valid = 1'b1;
    ifb.in_sel   = 3'd7;
    for (int i = 0; i < 300; i++) begin
      ifb.in_data = 8'(i);
      tick();
    end
    ifb.in_sel = 3'd5;
    tick();
    ifb.in_sel = 3'd6;
    tick();
    ifb.in_valid = 1'b0;
    tick();

    // Reset while three channels are full and stalled
    ifa.out_ready = 4'h0;
    for (int i = 0; i < 3; i++) begin
      drive_a(1'b1, 2'(i), 8'h31 + 8'(i));
      tick();
    end
    drive_a(1'b0, 2'd0, 8'h00);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    ifa.out_ready = 4'hF;
    drive_a(1'b1, 2'd0, 8'h44);
    tick();
    drive_a(1'b0, 2'd0, 8'h00);
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
